wb_rr_arbiter: RTL and testbench



---
 rtl/wb_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin share of one pipelined Wishbone slave port.
// Build option ARB_TIMEOUT_EN: WAIT gives up after TIMEOUT and flags m_err_o.
module wb_rr_arbiter #(
  parameter int NUM_M      = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH/8,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_M-1:0]                m_stb_i,
  input  logic [NUM_M-1:0]                m_we_i,
  input  logic [NUM_M*ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [NUM_M*DATA_WIDTH-1:0]     m_data_i,
  input  logic [NUM_M*SEL_WIDTH-1:0]      m_sel_i,
  output logic [NUM_M-1:0]                m_stall_o,
  output logic [NUM_M-1:0]                m_ack_o,
  output logic [NUM_M-1:0]                m_err_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic [DATA_WIDTH-1:0]           s_data_o,
  output logic [SEL_WIDTH-1:0]            s_sel_o,
  input  logic                            s_stall_i,
  input  logic                            s_ack_i,
  input  logic [DATA_WIDTH-1:0]           s_data_i
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [GW:0] NUM_W = (GW+1)'(NUM_M);

  if (NUM_M < 2 || NUM_M > 8 || TIMEOUT < 1) begin : g_param_chk
    $error("wb_rr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grant, grant_nx;
  logic [GW-1:0] last, last_nx;
  logic [GW-1:0] pick;
  logic [GW:0]   rr_idx;
  logic          any_req;
  logic          gstb;
  logic          tmo;

  // scan last+1, last+2, ... modulo NUM_M; first requester wins
  always_comb begin
    pick    = last;
    any_req = 1'b0;
    rr_idx  = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      rr_idx = {1'b0, last} + (GW+1)'(k);
      if (rr_idx >= NUM_W)
        rr_idx = rr_idx - NUM_W;
      if (!any_req && m_stb_i[rr_idx[GW-1:0]]) begin
        any_req = 1'b1;
        pick    = rr_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    gstb     = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant == GW'(i)) begin
        gstb     = m_stb_i[i];
        s_we_o   = m_we_i[i];
        s_addr_o = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_data_o = m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o  = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt;

  assign tmo = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (state != WAIT)
      cnt <= '0;
    else if (!s_ack_i)
      cnt <= cnt + CW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    last_nx   = last;
    s_stb_o   = 1'b0;
    m_stall_o = '1;
    m_ack_o   = '0;
    m_err_o   = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_nx = pick;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        s_stb_o = gstb;
        if (!s_stall_i)
          m_stall_o[grant] = 1'b0;
        if (!gstb)
          state_nx = IDLE;
        else if (!s_stall_i)
          state_nx = WAIT;
      end
      WAIT: begin
        if (s_ack_i) begin
          m_ack_o[grant] = 1'b1;
          last_nx        = grant;
          state_nx       = IDLE;
        end else if (tmo) begin
          m_err_o[grant] = 1'b1;
          last_nx        = grant;
          state_nx       = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign m_data_o = s_data_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(NUM_M-1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last  <= last_nx;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios, then random traffic checked against
// a transaction-level reference (round-robin order, memory image, stall rule).
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]    m_stb, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdat;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_stall, m_ack, m_err;
  logic [DW-1:0]   m_rdat;
  logic            s_stb, s_we, s_stall, s_ack;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdat, s_rdat;
  logic [SW-1:0]   s_sel;

  wb_rr_arbiter #(
    .NUM_M(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SEL_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_stb_i(m_stb), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_data_i(m_wdat), .m_sel_i(m_sel),
    .m_stall_o(m_stall), .m_ack_o(m_ack), .m_err_o(m_err),
    .m_data_o(m_rdat),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_data_o(s_wdat), .s_sel_o(s_sel),
    .s_stall_i(s_stall), .s_ack_i(s_ack), .s_data_i(s_rdat)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // requester agents
  bit            r_busy[N], r_acc[N], r_we[N];
  logic [AW-1:0] r_addr[N];
  logic [DW-1:0] r_data[N];
  logic [SW-1:0] r_sel[N];
  bit            acc_f[N], done_f[N];

  // slave RAM and reference image
  logic [DW-1:0] smem[512];
  logic [DW-1:0] rmem[512];
  int            ack_wait = -1;
  logic [DW-1:0] ack_rd;
  bit            noack = 0;
  int            ack_lo = 0, ack_hi = 0;
  int            stall_force = 0;
  int            stall_pct = 0, req_pct = 0, wd_pct = 0;
  bit            chk_en = 0;

  // reference: who is being served and in which phase
  typedef enum {P_IDLE, P_ISSUE, P_WAIT} ph_t;
  ph_t           ph = P_IDLE;
  int            g = 0, last = N-1, wcnt = 0;
  logic [DW-1:0] exp_rd;
  int            ack_log[$];

  function automatic int rr_pick(input logic [N-1:0] req, input int from);
    for (int k = 1; k <= N; k++)
      if (req[(from+k)%N]) return (from+k)%N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
      input logic [DW-1:0] n, input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < SW; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      m_stb[i] = r_busy[i] && !r_acc[i];
      m_we[i]  = r_we[i];
      m_addr[i*AW +: AW] = r_addr[i];
      m_wdat[i*DW +: DW] = r_data[i];
      m_sel[i*SW +: SW]  = r_sel[i];
    end
  endtask

  task automatic new_req(input int i, input bit we,
      input logic [AW-1:0] a, input logic [DW-1:0] d,
      input logic [SW-1:0] s);
    r_busy[i] = 1;
    r_acc[i]  = 0;
    r_we[i]   = we;
    r_addr[i] = a;
    r_data[i] = d;
    r_sel[i]  = s;
  endtask

  task automatic drive();
    s_ack  = 1'b0;
    s_rdat = $urandom;
    if (ack_wait == 0) begin
      s_ack    = 1'b1;
      s_rdat   = ack_rd;
      ack_wait = -1;
    end else if (ack_wait > 0) begin
      ack_wait--;
    end
    if (stall_force >= 0) s_stall = (stall_force != 0);
    else s_stall = ($urandom_range(99, 0) < stall_pct);
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        r_busy[i] = 0;
        r_acc[i]  = 0;
      end else begin
        if (done_f[i]) begin
          r_busy[i] = 0;
          r_acc[i]  = 0;
        end else if (acc_f[i]) begin
          r_acc[i] = 1;
        end else if (r_busy[i] && !r_acc[i] &&
                     $urandom_range(99, 0) < wd_pct) begin
          r_busy[i] = 0;
        end
        if (!r_busy[i] && $urandom_range(99, 0) < req_pct)
          new_req(i, 1'($urandom_range(1, 0)),
                  AW'($urandom_range(15, 0) + 256*$urandom_range(1, 0)),
                  $urandom, SW'($urandom));
      end
    end
    pack();
  endtask

  // one clock: check at negedge, advance reference, drive after posedge
  task automatic step();
    logic [N-1:0] e_stall, e_ack, e_err;
    logic         e_sstb;
    @(negedge clk);
    e_stall = '1;
    e_ack   = '0;
    e_err   = '0;
    e_sstb  = 1'b0;
    if (ph == P_ISSUE) begin
      e_sstb = m_stb[g];
      if (!s_stall) e_stall[g] = 1'b0;
    end
    if (ph == P_WAIT) begin
      if (s_ack) e_ack[g] = 1'b1;
`ifdef ARB_TIMEOUT_EN
      else if (wcnt == TO) e_err[g] = 1'b1;
`endif
    end
    if (chk_en) begin
      chk("stall", m_stall, e_stall);
      chk("s_stb", s_stb, e_sstb);
      chk("ack", m_ack, e_ack);
      chk("err", m_err, e_err);
      chk("m_data", m_rdat, s_rdat);
      if (e_sstb) begin
        chk("s_we", s_we, r_we[g]);
        chk("s_addr", s_addr, r_addr[g]);
        if (r_we[g]) begin
          chk("s_wdat", s_wdat, r_data[g]);
          chk("s_sel", s_sel, r_sel[g]);
        end
      end
      if (e_ack != 0 && !r_we[g]) chk("rd_data", m_rdat, exp_rd);
      if (m_ack != 0) ack_log.push_back(oh_idx(m_ack));
    end
    for (int i = 0; i < N; i++) begin
      acc_f[i]  = m_stb[i] && !m_stall[i];
      done_f[i] = m_ack[i] || m_err[i];
    end
    if (s_stb && !s_stall) begin
      if (s_we) smem[s_addr] = merge(smem[s_addr], s_wdat, s_sel);
      ack_rd = smem[s_addr];
      if (!noack) ack_wait = $urandom_range(ack_hi, ack_lo);
    end
    if (!rst) begin
      ph   = P_IDLE;
      last = N-1;
    end else begin
      case (ph)
        P_IDLE: if (m_stb != 0) begin
          g  = rr_pick(m_stb, last);
          ph = P_ISSUE;
        end
        P_ISSUE: if (!m_stb[g]) begin
          ph = P_IDLE;
        end else if (!s_stall) begin
          if (r_we[g])
            rmem[r_addr[g]] = merge(rmem[r_addr[g]], r_data[g], r_sel[g]);
          else
            exp_rd = rmem[r_addr[g]];
          ph   = P_WAIT;
          wcnt = 0;
        end
        P_WAIT: if (s_ack) begin
          last = g;
          ph   = P_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wcnt == TO) begin
          last = g;
          ph   = P_IDLE;
        end else begin
          wcnt++;
        end
`endif
        default: ph = P_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic peek();
    #2;
  endtask

  task automatic wait_done(input int maxc);
    bit ok;
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      step();
      peek();
      if ((m_ack | m_err) != 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_tmo", ok, 1);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    req_pct     = 0;
    wd_pct      = 0;
    stall_pct   = 0;
    stall_force = 0;
    noack       = 0;
    ack_lo      = 0;
    ack_hi      = 0;
    ack_wait    = -1;
    for (int i = 0; i < N; i++) begin
      r_busy[i] = 0;
      r_acc[i]  = 0;
    end
    pack();
    step();
    chk_en = 1;
    step();
    rst = 1'b1;
  endtask

  int exp_o[5] = '{0, 1, 2, 3, 0};
  int n;

  initial begin
    for (int a = 0; a < 512; a++) begin
      smem[a] = '0;
      rmem[a] = '0;
    end
    for (int i = 0; i < N; i++) begin
      r_busy[i] = 0; r_acc[i] = 0; r_we[i] = 0;
      r_addr[i] = '0; r_data[i] = '0; r_sel[i] = '0;
      acc_f[i] = 0; done_f[i] = 0;
    end
    rst = 1'b0;
    s_stall = 1'b0;
    s_ack = 1'b0;
    s_rdat = '0;
    pack();

    // reset values, then write and read back through requester 2
    do_reset();
    peek();
    chk("rst_stall", m_stall, 4'hF);
    chk("rst_sstb", s_stb, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    new_req(2, 1, 9'h005, 32'hDEADBEEF, 4'hF);
    pack();
    step();
    peek();
    chk("t1_sstb", s_stb, 1);
    chk("t1_we", s_we, 1);
    chk("t1_addr", s_addr, 9'h005);
    chk("t1_data", s_wdat, 32'hDEADBEEF);
    chk("t1_sel", s_sel, 4'hF);
    chk("t1_stall", m_stall, 4'b1011);
    step();
    peek();
    chk("t1_ack", m_ack, 4'b0100);
    step();
    peek();
    new_req(2, 0, 9'h005, '0, 4'hF);
    pack();
    wait_done(20);
    chk("t1_rdack", m_ack, 4'b0100);
    chk("t1_rd", m_rdat, 32'hDEADBEEF);
    step();

    // everyone requesting continuously
    do_reset();
    req_pct = 100;
    for (int i = 0; i < N; i++)
      new_req(i, 1'($urandom_range(1, 0)), AW'(i), $urandom, 4'hF);
    pack();
    ack_log.delete();
    for (int c = 0; c < 60 && ack_log.size() < 5; c++) step();
    chk("t2_n", ack_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < ack_log.size(); k++)
      chk($sformatf("t2_order%0d", k), ack_log[k], exp_o[k]);
    req_pct = 0;
    for (int c = 0; c < 6; c++) step();

    // slave stall held for three ISSUE cycles
    do_reset();
    stall_force = 1;
    new_req(1, 0, 9'h105, '0, 4'hF);
    pack();
    step();
    for (int k = 0; k < 3; k++) begin
      peek();
      chk($sformatf("t3_stall%0d", k), m_stall[1], 1);
      chk($sformatf("t3_sstb%0d", k), s_stb, 1);
      if (k == 2) stall_force = 0;
      step();
    end
    peek();
    chk("t3_go", m_stall, 4'b1101);
    step();
    peek();
    chk("t3_ack", m_ack, 4'b0010);
    step();

    // requester 3 withdraws before acceptance
    do_reset();
    stall_force = 1;
    new_req(3, 1, 9'h033, 32'h0BADF00D, 4'hF);
    pack();
    step();
    peek();
    chk("t4_sstb", s_stb, 1);
    r_busy[3] = 0;
    new_req(0, 1, 9'h00A, 32'h12345678, 4'hF);
    pack();
    #1;
    chk("t4_drop", s_stb, 0);
    stall_force = 0;
    wait_done(20);
    chk("t4_ack0", m_ack, 4'b0001);
    step();

    // reset while in WAIT, late slave ack must be dropped
    do_reset();
    new_req(0, 1, 9'h020, $urandom, 4'hF);
    pack();
    wait_done(20);
    step();
    peek();
    ack_lo = 3;
    ack_hi = 3;
    new_req(1, 0, 9'h020, '0, 4'hF);
    pack();
    step();
    step();
    peek();
    rst = 1'b0;
    step();
    rst = 1'b1;
    peek();
    chk("t5_stall", m_stall, 4'hF);
    chk("t5_sstb", s_stb, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      peek();
      chk($sformatf("t5_noack%0d", c), m_ack, 0);
    end
    ack_lo = 0;
    ack_hi = 0;
    new_req(0, 0, 9'h020, '0, 4'hF);
    new_req(1, 0, 9'h021, '0, 4'hF);
    pack();
    wait_done(20);
    chk("t5_grant0", m_ack, 4'b0001);
    step();
    for (int c = 0; c < 8; c++) step();

`ifdef ARB_TIMEOUT_EN
    // slave never acks: error after TIMEOUT cycles in WAIT
    do_reset();
    noack = 1;
    new_req(0, 0, 9'h040, '0, 4'hF);
    new_req(1, 0, 9'h041, '0, 4'hF);
    pack();
    step();
    step();
    peek();
    n = 0;
    while (m_err == 0 && n < 40) begin
      step();
      peek();
      n++;
    end
    chk("t6_delay", n, TO);
    chk("t6_err", m_err, 4'b0001);
    noack = 0;
    wait_done(20);
    chk("t6_next", m_ack, 4'b0010);
    step();
`endif

    // random traffic
    do_reset();
    stall_force = -1;
    stall_pct   = 30;
    req_pct     = 25;
    wd_pct      = 3;
    ack_lo      = 0;
    ack_hi      = 2;
    for (int c = 0; c < 3000; c++) step();
    req_pct     = 0;
    wd_pct      = 0;
    stall_force = 0;
    for (int c = 0; c < 30; c++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
